// File: rtl/btn_cmd_conditioner.sv
// btn_cmd_conditioner
// Turns raw, bouncy, asynchronous push-buttons into clean debounced levels,
// single-cycle press/release strobes and a priority-arbitrated one-hot
// command strobe (bit 0 wins). Presses that lose arbitration are not queued;
// they only raise cmd_dropped for that cycle.
module btn_cmd_conditioner #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] cmd_onehot,
    output logic               cmd_dropped
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam bit CFG_OK = (DEBOUNCE_CYCLES >= 2) &&
                            ((CNT_W >= 32) || ((64'd1 << CNT_W) > 64'(DEBOUNCE_CYCLES)));

    logic [NUM_BTN-1:0] sync1_q, sync1_d;
    logic [NUM_BTN-1:0] sync2_q, sync2_d;
    logic [CNT_W-1:0]   cnt_q [NUM_BTN];
    logic [CNT_W-1:0]   cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] level_q, level_d;
    logic [NUM_BTN-1:0] press_q, press_d;
    logic [NUM_BTN-1:0] release_q, release_d;
    logic [NUM_BTN-1:0] cmd_q, cmd_d;
    logic               dropped_q, dropped_d;

    // Next-state: synchronizer, per-bit debounce, edge detect and arbitration.
    // Edges and arbitration are taken from level_d so that press, release and
    // cmd all register on the same edge as the level change.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        press_d   = level_d & ~level_q;
        release_d = ~level_d & level_q;
        cmd_d     = press_d & (~press_d + NUM_BTN'(1));
        dropped_d = (press_d & (press_d - NUM_BTN'(1))) != '0;
    end

    // State registers; async reset clears everything including counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                cnt_q[i] <= '0;
            end
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            cmd_q     <= '0;
            dropped_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            cmd_q     <= cmd_d;
            dropped_q <= dropped_d;
        end
    end

    // Configuration check: debounce window must be >= 2 and fit the counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cfg_check: assert (CFG_OK)
                else $error("btn_cmd_conditioner: illegal DEBOUNCE_CYCLES/CNT_W");
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign cmd_onehot  = cmd_q;
    assign cmd_dropped = dropped_q;

endmodule

// File: tb/tb_btn_cmd_conditioner.sv
// Testbench for btn_cmd_conditioner: directed scenarios followed by random
// bouncy stimulus with random resets. A reference model records what the
// synchronizer delivers each edge and accepts a level change only when the
// last DEBOUNCE_CYCLES delivered samples all disagree with the level and no
// change/reset happened inside that window. Expected outputs are queued per
// edge; a monitor pops and compares at each falling edge.
module tb_btn_cmd_conditioner;

    localparam int N  = 4;
    localparam int DC = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] btn_level, btn_press, btn_release, cmd_onehot;
    logic         cmd_dropped;

    btn_cmd_conditioner #(
        .NUM_BTN        (N),
        .DEBOUNCE_CYCLES(DC),
        .CNT_W          (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .cmd_onehot (cmd_onehot),
        .cmd_dropped(cmd_dropped)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] lvl;
        logic [N-1:0] prs;
        logic [N-1:0] rel;
        logic [N-1:0] cmd;
        logic         drp;
    } exp_t;

    exp_t         exp_q[$];
    logic [N-1:0] hist[$];
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: one expected entry per rising edge.
    initial begin
        logic [N-1:0] m_lvl, new_lvl;
        int           last_chg[N];
        int           k;
        bit           all_diff;
        exp_t         e;
        m_lvl = '0;
        k     = 0;
        hist.push_back('0);
        for (int i = 0; i < N; i++) last_chg[i] = 1;
        forever begin
            @(posedge clk);
            k++;
            e = '0;
            if (rst) begin
                // Async reset wipes both synchronizer stages.
                hist.push_back('0);
                hist[k-1] = '0;
                m_lvl = '0;
                for (int i = 0; i < N; i++) last_chg[i] = k;
            end else begin
                hist.push_back(btn_raw);
                new_lvl = m_lvl;
                for (int i = 0; i < N; i++) begin
                    if (k - last_chg[i] >= DC) begin
                        all_diff = 1'b1;
                        for (int j = 2; j <= DC + 1; j++)
                            if (hist[k-j][i] == m_lvl[i]) all_diff = 1'b0;
                        if (all_diff) begin
                            new_lvl[i]  = ~m_lvl[i];
                            last_chg[i] = k;
                        end
                    end
                end
                e.lvl = new_lvl;
                e.prs = new_lvl & ~m_lvl;
                e.rel = m_lvl & ~new_lvl;
                for (int i = 0; i < N; i++) begin
                    if (e.prs[i]) begin
                        e.cmd[i] = 1'b1;
                        break;
                    end
                end
                e.drp = ($countones(e.prs) > 1);
                m_lvl = new_lvl;
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: compare DUT outputs against the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                chk("queue_empty", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("btn_level",   32'(btn_level),   32'(e.lvl));
                chk("btn_press",   32'(btn_press),   32'(e.prs));
                chk("btn_release", 32'(btn_release), 32'(e.rel));
                chk("cmd_onehot",  32'(cmd_onehot),  32'(e.cmd));
                chk("cmd_dropped", 32'(cmd_dropped), 32'(e.drp));
            end
        end
    end

    task automatic step(input logic [N-1:0] v);
        @(negedge clk);
        #1 btn_raw = v;
    endtask

    task automatic hold(input logic [N-1:0] v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < n; i++) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [N-1:0] v;
        hold(4'b0000, 3);
        @(negedge clk);
        #1 rst = 1'b0;
        hold(4'b0000, 4);
        // Clean press and release
        hold(4'b0001, 12);
        hold(4'b0000, 12);
        // Bounce rejection
        step(4'b0010); step(4'b0000); step(4'b0010);
        step(4'b0010); step(4'b0010); step(4'b0000);
        hold(4'b0000, 10);
        // Bounce then settle
        hold(4'b0010, 3);
        step(4'b0000);
        hold(4'b0010, 12);
        hold(4'b0000, 12);
        // Simultaneous press
        hold(4'b0101, 12);
        hold(4'b0000, 12);
        // Release of a held button
        hold(4'b1000, 12);
        hold(4'b0000, 12);
        // Reset mid-count, button held through reset
        hold(4'b0100, 3);
        do_reset(2);
        hold(4'b0100, 12);
        hold(4'b0000, 12);
        // Random bouncy traffic with occasional resets
        for (int s = 0; s < 400; s++) begin
            case ($urandom_range(0, 19))
                0: do_reset($urandom_range(1, 3));
                1, 2, 3, 4, 5, 6: begin
                    for (int c = 0; c < $urandom_range(1, 4); c++) begin
                        v = btn_raw ^ N'($urandom_range(0, 15));
                        step(v);
                    end
                end
                default: hold(N'($urandom_range(0, 15)), $urandom_range(1, 10));
            endcase
        end
        hold(4'b0000, 12);
        @(negedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_cmd_conditioner.md
Name: btn_cmd_conditioner

Overview:
- Input-side counterpart to the ALU/display datapath. It turns raw, bouncy, asynchronous push-buttons (store1, store2, add, sub) into clean, synchronized, single-cycle command strobes.
- Per-button flow: 2-FF synchronizer, then debounce counter, then edge detector. A priority arbiter then emits at most one command pulse per cycle.
- The downstream ALU register stage consumes cmd_onehot instead of level-sensitive raw buttons.

Parameters:
- NUM_BTN, 4: number of buttons. Bit 0 has the highest priority (store1, store2, add, sub order).
- DEBOUNCE_CYCLES, 500000: consecutive stable clocks required to accept a level change (10 ms at 50 MHz). Legal minimum is 2.
- CNT_W, 20: counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- btn_raw  in  NUM_BTN  raw button inputs, asynchronous to clk, active-high.
- btn_level  out  NUM_BTN  debounced button state.
- btn_press  out  NUM_BTN  one-cycle pulse on each debounced 0->1 transition.
- btn_release  out  NUM_BTN  one-cycle pulse on each debounced 1->0 transition.
- cmd_onehot  out  NUM_BTN  btn_press masked to its lowest set bit; zero or one-hot.
- cmd_dropped  out  1  one-cycle pulse when more than one btn_press bit is set in the same cycle.

Behaviour:
- Reset (async assert, sync use after deassert) clears all of the following to 0:
  - sync1, sync2
  - all counters
  - btn_level, btn_press, btn_release, cmd_onehot, cmd_dropped
- Synchronizer, per bit: sync1 <= btn_raw; sync2 <= sync1. No logic between the two stages.
- Debounce, per bit i, evaluated each edge:
  - If sync2[i] == btn_level[i]: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: btn_level[i] <= sync2[i]; counter <= 0.
  - Else: counter <= counter + 1.
  - Any single-cycle agreement between sync2 and btn_level restarts the count.
  - The counter never exceeds DEBOUNCE_CYCLES-1, so it cannot wrap.
- Latency: a clean raw edge stable before rising edge E1 is reflected on btn_level after edge E(DEBOUNCE_CYCLES+2).
- Edges (all outputs registered):
  - btn_press[i] is high exactly in the cycle btn_level[i] first reads 1.
  - btn_release[i] is high exactly in the cycle btn_level[i] first reads 0.
  - A held button produces exactly one press pulse; no auto-repeat.
- Arbiter (registered in the same edge as btn_press, so aligned with it):
  - cmd_onehot = next_press & (~next_press + 1), i.e. the lowest set bit.
  - cmd_dropped = 1 when next_press has two or more bits set.
  - Dropped presses are not queued. Their btn_level and btn_press still behave normally.
- Simultaneous press on one bit and release on another: both pulses appear. A release never produces a cmd_onehot bit.
- Mid-operation reset:
  - All counting is lost; no pulse is emitted during or on exit from reset.
  - A button held through reset release is seen as a new press after DEBOUNCE_CYCLES+2 edges.
- Reset deassertion with btn_raw all 0 produces no outputs.
- Parameter checks: DEBOUNCE_CYCLES < 2 or 2^CNT_W <= DEBOUNCE_CYCLES is a configuration error, flagged by a simulation-time assertion.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and NUM_BTN=4.
- Clean press: btn_raw 0000->0001 before E1, held.
  -> btn_level=0001 after E6.
  -> btn_press=0001 and cmd_onehot=0001 for exactly one cycle (E6-E7), then 0000 while held.
- Bounce rejection: btn_raw[1] toggles 1,0,1,1,1,0 on consecutive cycles.
  -> btn_level stays 0000; no press, no cmd.
- Bounce then settle: btn_raw[1] high for 3 cycles, low 1, then high held.
  -> Exactly one btn_press=0010, at 6 edges after the final rise.
- Simultaneous press: btn_raw 0000->0101 in one cycle.
  -> btn_press=0101, cmd_onehot=0001, cmd_dropped=1, all in the same single cycle.
- Release: from held 1000, btn_raw->0000.
  -> btn_release=1000 for one cycle 6 edges later; cmd_onehot stays 0000.
- Reset mid-count: btn_raw[2] rises, assert rst between E3 and E4 for 2 cycles while still held.
  -> All outputs 0 during reset.
  -> btn_press=0100 exactly once, 6 edges after rst deasserts.
